// File: rtl/prog_clk_div.sv
// Runtime-programmable clock/strobe divider with TOGGLE, PULSE and PWM output modes.
// Optional phase-alignment input sync_in is compiled in when CLKDIV_SYNC_EN is defined.
module prog_clk_div #(
   parameter int          WIDTH       = 32,
   parameter int unsigned DEFAULT_DIV = 50000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_in,
   input  logic [WIDTH-1:0] duty_in,
   input  logic [1:0]       mode_in,
   output logic             busy,
   output logic             load_ack,
   output logic             tick,
   output logic             clk_out
`ifdef CLKDIV_SYNC_EN
   ,
   input  logic             sync_in
`endif
);

   localparam logic [1:0] MODE_TOGGLE = 2'b00;
   localparam logic [1:0] MODE_PULSE  = 2'b01;
   localparam logic [1:0] MODE_PWM    = 2'b10;

   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] DEF_DUTY = WIDTH'(DEFAULT_DIV / 2);

   logic [WIDTH-1:0] cnt, div_r, duty_r, sh_div, sh_duty;
   logic [1:0]       mode_r, sh_mode;

   logic [WIDTH-1:0] cnt_nx, div_nx, duty_nx;
   logic [1:0]       mode_nx;
   logic             clk_out_nx;
   logic             term, sync_hit, apply;

   assign term = (cnt == div_r - ONE);

`ifdef CLKDIV_SYNC_EN
   assign sync_hit = en & sync_in;
`else
   assign sync_hit = 1'b0;
`endif

   assign tick = en & term & ~sync_hit;

   // A pending load lands on a terminal count, a sync pulse, or at once while disabled.
   assign apply = busy & (~en | tick | sync_hit);

   always_comb begin
      cnt_nx     = cnt;
      div_nx     = div_r;
      duty_nx    = duty_r;
      mode_nx    = mode_r;
      clk_out_nx = clk_out;

      if (apply) begin
         div_nx  = sh_div;
         duty_nx = sh_duty;
         mode_nx = sh_mode;
      end

      if (apply || sync_hit)
         cnt_nx = '0;
      else if (en)
         cnt_nx = term ? '0 : cnt + ONE;

      // The mode in force after this edge decides the output value.
      if (en || apply) begin
         case (mode_nx)
            MODE_PULSE: clk_out_nx = (apply || sync_hit) ? 1'b0 : tick;
            MODE_PWM:   clk_out_nx = (cnt_nx < duty_nx);
            default:    clk_out_nx = sync_hit ? 1'b0 : (clk_out ^ (tick & ~apply));
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         div_r    <= DEF_DIV;
         duty_r   <= DEF_DUTY;
         mode_r   <= MODE_TOGGLE;
         clk_out  <= 1'b0;
         busy     <= 1'b0;
         load_ack <= 1'b0;
         sh_div   <= '0;
         sh_duty  <= '0;
         sh_mode  <= MODE_TOGGLE;
      end else begin
         cnt      <= cnt_nx;
         div_r    <= div_nx;
         duty_r   <= duty_nx;
         mode_r   <= mode_nx;
         clk_out  <= clk_out_nx;
         load_ack <= apply;

         if (apply) begin
            busy <= 1'b0;
         end else if (div_load && !busy) begin
            busy    <= 1'b1;
            sh_div  <= (div_in == '0) ? ONE : div_in;
            sh_duty <= duty_in;
            sh_mode <= mode_in;
         end
      end
   end

endmodule

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
Runtime-programmable clock/strobe generator. Successor to the fixed-divisor toggle divider. Adds a programmable period, three output modes (toggle, single-cycle pulse, PWM) and a load handshake that applies new settings glitch-free at a period boundary. Sits beside the system clock and feeds enables, blink/PWM outputs and peripheral strobes.

Parameters:
WIDTH, 32, width of counter, divisor and duty registers
DEFAULT_DIV, 50000000, period in clk cycles after reset (must be >=1 and fit in WIDTH)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  count enable; low freezes all state
div_load  input  1  request to capture div_in/duty_in/mode_in
div_in  input  WIDTH  new period in clk cycles
duty_in  input  WIDTH  new PWM high time in clk cycles
mode_in  input  2  00 TOGGLE, 01 PULSE, 10 PWM, 11 reserved (acts as TOGGLE)
busy  output  1  load pending (shadow captured, not yet applied)
load_ack  output  1  one-cycle pulse, cycle after settings become active
tick  output  1  one-cycle terminal-count strobe
clk_out  output  1  divided/PWM output, registered

Behaviour:
- Reset (async): cnt=0, div_r=DEFAULT_DIV, duty_r=DEFAULT_DIV/2, mode_r=TOGGLE; clk_out=0, tick=0, busy=0, load_ack=0; shadow regs cleared.
- Counter: when en=1, cnt wraps to 0 if cnt==div_r-1, else cnt+1. When en=0, cnt, clk_out and mode/div regs hold, and tick=0.
- tick=1 exactly in cycles where en=1 and cnt==div_r-1. Mode independent, combinational from registers.
- TOGGLE: clk_out inverts on each terminal count. Output period = 2*div_r.
- PULSE: clk_out registered high for one cycle following each terminal count, i.e. delayed tick. Low otherwise.
- PWM: clk_out register is loaded with (cnt_next < duty_next), so clk_out==1 exactly while cnt<duty_r. duty_r=0 gives constant 0. duty_r>=div_r gives constant 1.
- Divisor clamp: div_in=0 is stored as 1. With div_r=1, every enabled cycle is terminal. TOGGLE gives clk/2; PULSE gives clk_out constantly high after the first cycle.
- Load handshake:
  - div_load=1 while busy=0: capture div_in/duty_in/mode_in into shadow regs; busy=1 next cycle.
  - div_load while busy=1: ignored, no ack.
  - Apply on the first terminal-count cycle while busy (en=1). If en=0, apply on the next clk edge instead.
  - On apply: active regs take the shadow values, cnt=0, busy=0; load_ack=1 for the following cycle.
  - New mode's clk_out rule governs from the apply edge. TOGGLE resumes from the current clk_out value. PULSE forces 0 at the apply edge. PWM evaluates with cnt=0.
- Simultaneous div_load and apply cycle with busy=0 is impossible, since apply requires busy=1. A request landing on the terminal cycle is captured and applied at the following terminal count.
- Reset mid-operation drops any pending load and restores defaults.
- No arithmetic overflow: cnt never exceeds div_r-1. All comparisons are unsigned WIDTH-bit.

Optional Feature:
CLKDIV_SYNC_EN.
- Defined: adds input sync_in (1). sync_in=1 with en=1 forces cnt=0 next cycle and suppresses tick that cycle. Any pending load is applied at that edge, with normal load_ack. clk_out becomes 0 in TOGGLE/PULSE, or (0<duty_r) in PWM. This lets several dividers be phase-aligned.
- Not defined: the sync_in port does not exist and behaviour is as above.

Test Plan:
- DEFAULT_DIV=4, TOGGLE, en=1 after reset -> tick at cnt=3 every 4 clks; clk_out 0000111100001111...
- With div=4 running, load div_in=3, mode PULSE at cnt=1 -> busy=1 until the tick at cnt=3; load_ack next cycle; then clk_out high 1 of every 3 clks.
- PWM div_in=5 duty_in=2 -> clk_out 11000 repeating. duty_in=0 -> constant 0. duty_in=7 -> constant 1.
- en=0 for 10 cycles at cnt=2 -> cnt and clk_out frozen, tick=0. div_load during en=0 -> applied next edge, load_ack next cycle.
- div_in=0 TOGGLE -> clk_out toggles every enabled cycle. A second div_load while busy=1 is ignored, with exactly one load_ack.
- rst pulse mid-period with busy=1 -> all outputs 0 immediately, busy=0, period returns to DEFAULT_DIV. With CLKDIV_SYNC_EN, sync_in at cnt=2 -> cnt=0 next cycle, no tick.
